// File: rtl/lpixm_axi_master_mo.sv
// LPI request/response master to single-ID AXI4 master bridge with burst writes,
// multiple outstanding transactions and in-order mixed read/write response return.
module lpixm_axi_master_mo #(
   parameter int unsigned BW_ADDR         = 32,
   parameter int unsigned BW_DATA         = 32,
   parameter int unsigned BW_AXI_ID       = 1,
   parameter int unsigned AXI_ID          = 0,
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned MAX_BURST_LEN   = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic                   busy,
   // LPI request
   input  logic                   sreq_valid,
   output logic                   sreq_ready,
   input  logic                   sreq_write,
   input  logic [BW_ADDR-1:0]     sreq_addr,
   input  logic [7:0]             sreq_len,
   input  logic [BW_DATA-1:0]     sreq_wdata,
   input  logic [BW_DATA/8-1:0]   sreq_wstrb,
   // LPI response
   output logic                   sresp_valid,
   input  logic                   sresp_ready,
   output logic                   sresp_write,
   output logic [BW_DATA-1:0]     sresp_data,
   output logic                   sresp_err,
   output logic                   sresp_last,
   // AXI write address
   output logic [BW_AXI_ID-1:0]   awid,
   output logic [BW_ADDR-1:0]     awaddr,
   output logic [7:0]             awlen,
   output logic [2:0]             awsize,
   output logic [1:0]             awburst,
   output logic                   awvalid,
   input  logic                   awready,
   // AXI write data
   output logic [BW_DATA-1:0]     wdata,
   output logic [BW_DATA/8-1:0]   wstrb,
   output logic                   wlast,
   output logic                   wvalid,
   input  logic                   wready,
   // AXI write response
   input  logic [BW_AXI_ID-1:0]   bid,
   input  logic [1:0]             bresp,
   input  logic                   bvalid,
   output logic                   bready,
   // AXI read address
   output logic [BW_AXI_ID-1:0]   arid,
   output logic [BW_ADDR-1:0]     araddr,
   output logic [7:0]             arlen,
   output logic [2:0]             arsize,
   output logic [1:0]             arburst,
   output logic                   arvalid,
   input  logic                   arready,
   // AXI read data
   input  logic [BW_AXI_ID-1:0]   rid,
   input  logic [BW_DATA-1:0]     rdata,
   input  logic [1:0]             rresp,
   input  logic                   rlast,
   input  logic                   rvalid,
   output logic                   rready
);

   localparam int unsigned BW_STRB = BW_DATA / 8;
   localparam int unsigned PtrW    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int unsigned CntW    = PtrW + 1;
   localparam logic [7:0]  MaxLen  = 8'(MAX_BURST_LEN - 1);

   typedef enum logic [0:0] {StIdle, StWburst} state_e;

   state_e               state_q, state_d;
   logic [7:0]           beat_cnt_q, beat_cnt_d;
   logic [7:0]           burst_len_q, burst_len_d;

   logic                 arvalid_q, arvalid_d;
   logic [BW_ADDR-1:0]   araddr_q, araddr_d;
   logic [7:0]           arlen_q, arlen_d;
   logic                 awvalid_q, awvalid_d;
   logic [BW_ADDR-1:0]   awaddr_q, awaddr_d;
   logic [7:0]           awlen_q, awlen_d;
   logic                 wvalid_q, wvalid_d;
   logic [BW_DATA-1:0]   wdata_q, wdata_d;
   logic [BW_STRB-1:0]   wstrb_q, wstrb_d;
   logic                 wlast_q, wlast_d;

   // Order FIFO: one type bit per outstanding transaction, 1 = write
   logic [MAX_OUTSTANDING-1:0] ord_q;
   logic [PtrW-1:0]            rd_ptr_q, wr_ptr_q;
   logic [CntW-1:0]            cnt_q;
   logic                       fifo_full, fifo_empty, fifo_space, head_write;
   logic                       push, push_write, pop;

   logic [7:0]           len_clamp;
   logic                 sreq_fire;
   logic                 unused_ok;

   assign unused_ok  = ^{bid, rid, bresp[0], rresp[0]};

   assign len_clamp  = ({1'b0, sreq_len} >= 9'(MAX_BURST_LEN)) ? MaxLen : sreq_len;
   assign fifo_full  = (cnt_q == CntW'(MAX_OUTSTANDING));
   assign fifo_empty = (cnt_q == '0);
   assign head_write = ord_q[rd_ptr_q];
   // A retiring transaction frees its slot for a push in the same cycle
   assign fifo_space = !fifo_full || pop;

   // Response path: head of the order FIFO steers sresp to R or B
   always_comb begin
      sresp_valid = 1'b0;
      sresp_write = 1'b0;
      sresp_data  = '0;
      sresp_err   = 1'b0;
      sresp_last  = 1'b0;
      rready      = 1'b0;
      bready      = 1'b0;
      pop         = 1'b0;
      if (!fifo_empty) begin
         if (head_write) begin
            sresp_valid = bvalid;
            sresp_write = 1'b1;
            sresp_err   = bresp[1];
            sresp_last  = 1'b1;
            bready      = sresp_ready;
            pop         = bvalid && sresp_ready;
         end else begin
            sresp_valid = rvalid;
            sresp_data  = rdata;
            sresp_err   = rresp[1];
            sresp_last  = rlast;
            rready      = sresp_ready;
            pop         = rvalid && sresp_ready && rlast;
         end
      end
   end

   always_comb begin
      sreq_ready = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (sreq_write) sreq_ready = fifo_space && !awvalid_q && !wvalid_q;
            else            sreq_ready = fifo_space && (!arvalid_q || arready);
         end
         StWburst: sreq_ready = !wvalid_q || wready;
         default:  sreq_ready = 1'b0;
      endcase
      if (rst) sreq_ready = 1'b0;
   end

   assign sreq_fire = sreq_valid && sreq_ready;

   always_comb begin
      state_d     = state_q;
      beat_cnt_d  = beat_cnt_q;
      burst_len_d = burst_len_q;
      arvalid_d   = arvalid_q && !arready;
      araddr_d    = araddr_q;
      arlen_d     = arlen_q;
      awvalid_d   = awvalid_q && !awready;
      awaddr_d    = awaddr_q;
      awlen_d     = awlen_q;
      wvalid_d    = wvalid_q && !wready;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      wlast_d     = wlast_q;
      push        = 1'b0;
      push_write  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (sreq_fire) begin
               push       = 1'b1;
               push_write = sreq_write;
               if (sreq_write) begin
                  awvalid_d   = 1'b1;
                  awaddr_d    = sreq_addr;
                  awlen_d     = len_clamp;
                  wvalid_d    = 1'b1;
                  wdata_d     = sreq_wdata;
                  wstrb_d     = sreq_wstrb;
                  wlast_d     = (len_clamp == 8'd0);
                  beat_cnt_d  = 8'd0;
                  burst_len_d = len_clamp;
                  if (len_clamp != 8'd0) state_d = StWburst;
               end else begin
                  arvalid_d = 1'b1;
                  araddr_d  = sreq_addr;
                  arlen_d   = len_clamp;
               end
            end
         end
         StWburst: begin
            if (sreq_fire) begin
               beat_cnt_d = beat_cnt_q + 8'd1;
               wvalid_d   = 1'b1;
               wdata_d    = sreq_wdata;
               wstrb_d    = sreq_wstrb;
               wlast_d    = (beat_cnt_d == burst_len_q);
               if (beat_cnt_d == burst_len_q) state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         beat_cnt_q  <= '0;
         burst_len_q <= '0;
         arvalid_q   <= 1'b0;
         araddr_q    <= '0;
         arlen_q     <= '0;
         awvalid_q   <= 1'b0;
         awaddr_q    <= '0;
         awlen_q     <= '0;
         wvalid_q    <= 1'b0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         wlast_q     <= 1'b0;
         ord_q       <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         beat_cnt_q  <= beat_cnt_d;
         burst_len_q <= burst_len_d;
         arvalid_q   <= arvalid_d;
         araddr_q    <= araddr_d;
         arlen_q     <= arlen_d;
         awvalid_q   <= awvalid_d;
         awaddr_q    <= awaddr_d;
         awlen_q     <= awlen_d;
         wvalid_q    <= wvalid_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         wlast_q     <= wlast_d;
         if (push) begin
            ord_q[wr_ptr_q] <= push_write;
            wr_ptr_q        <= wr_ptr_q + PtrW'(1);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
         if (push && !pop)      cnt_q <= cnt_q + CntW'(1);
         else if (!push && pop) cnt_q <= cnt_q - CntW'(1);
      end
   end

   assign awid    = BW_AXI_ID'(AXI_ID);
   assign arid    = BW_AXI_ID'(AXI_ID);
   assign awsize  = 3'($clog2(BW_STRB));
   assign arsize  = 3'($clog2(BW_STRB));
   assign awburst = 2'b01;
   assign arburst = 2'b01;
   assign awaddr  = awaddr_q;
   assign awlen   = awlen_q;
   assign awvalid = awvalid_q;
   assign araddr  = araddr_q;
   assign arlen   = arlen_q;
   assign arvalid = arvalid_q;
   assign wdata   = wdata_q;
   assign wstrb   = wstrb_q;
   assign wlast   = wlast_q;
   assign wvalid  = wvalid_q;

   assign busy = !fifo_empty || arvalid_q || awvalid_q || wvalid_q || (state_q != StIdle);

endmodule

// File: tb/tb_lpixm_axi_master_mo.sv
// Bench for lpixm_axi_master_mo: vector tables for reads/writes plus hand-written
// ordering, back-pressure and reset sequences; responses checked via a scoreboard.
module tb_lpixm_axi_master_mo;

   logic        clk = 1'b0;
   logic        rst;
   logic        busy;
   logic        sreq_valid, sreq_ready, sreq_write;
   logic [31:0] sreq_addr;
   logic [7:0]  sreq_len;
   logic [31:0] sreq_wdata;
   logic [3:0]  sreq_wstrb;
   logic        sresp_valid, sresp_ready, sresp_write, sresp_err, sresp_last;
   logic [31:0] sresp_data;
   logic [0:0]  awid, bid, arid, rid;
   logic [31:0] awaddr, araddr, wdata, rdata;
   logic [7:0]  awlen, arlen;
   logic [2:0]  awsize, arsize;
   logic [1:0]  awburst, arburst, bresp, rresp;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rlast, rvalid, rready;
   logic [3:0]  wstrb;

   lpixm_axi_master_mo dut (
      .clk(clk), .rst(rst), .busy(busy),
      .sreq_valid(sreq_valid), .sreq_ready(sreq_ready), .sreq_write(sreq_write),
      .sreq_addr(sreq_addr), .sreq_len(sreq_len), .sreq_wdata(sreq_wdata),
      .sreq_wstrb(sreq_wstrb),
      .sresp_valid(sresp_valid), .sresp_ready(sresp_ready), .sresp_write(sresp_write),
      .sresp_data(sresp_data), .sresp_err(sresp_err), .sresp_last(sresp_last),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
      .rready(rready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  len;
      logic [31:0] data;
      logic [1:0]  resp;
      logic        exp_err;
      logic [7:0]  exp_len;
   } vec_t;

   typedef struct packed {
      logic        write;
      logic [31:0] data;
      logic        err;
      logic        last;
   } resp_t;

   resp_t sb[$];
   vec_t  rd_tab[5];
   vec_t  wr_tab[3];
   int    n_tests = 0;
   int    n_fail  = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_resp(input string name);
      resp_t e;
      if (sb.size() == 0) begin
         chk({name, "_sb_nonempty"}, 64'd0, 64'd1);
      end else begin
         e = sb.pop_front();
         chk({name, "_valid"}, 64'(sresp_valid), 64'd1);
         chk({name, "_write"}, 64'(sresp_write), 64'(e.write));
         chk({name, "_data"},  64'(sresp_data),  64'(e.data));
         chk({name, "_err"},   64'(sresp_err),   64'(e.err));
         chk({name, "_last"},  64'(sresp_last),  64'(e.last));
      end
   endtask

   task automatic do_read(input vec_t v, input int idx);
      string n;
      n = $sformatf("rd%0d", idx);
      sreq_valid = 1'b1; sreq_write = 1'b0; sreq_addr = v.addr; sreq_len = v.len;
      #1 chk({n, "_ready"}, 64'(sreq_ready), 64'd1);
      step();
      sreq_valid = 1'b0;
      #1;
      chk({n, "_arvalid"}, 64'(arvalid), 64'd1);
      chk({n, "_araddr"},  64'(araddr),  64'(v.addr));
      chk({n, "_arlen"},   64'(arlen),   64'(v.exp_len));
      chk({n, "_arsize"},  64'(arsize),  64'd2);
      chk({n, "_arburst"}, 64'(arburst), 64'd1);
      arready = 1'b1;
      step();
      arready = 1'b0;
      #1 chk({n, "_ar_done"}, 64'(arvalid), 64'd0);
      for (int i = 0; i <= int'(v.exp_len); i++) begin
         rvalid = 1'b1; rdata = v.data + 32'(i); rresp = v.resp;
         rlast = (i == int'(v.exp_len)); sresp_ready = 1'b1;
         sb.push_back('{write: 1'b0, data: v.data + 32'(i), err: v.exp_err,
                        last: (i == int'(v.exp_len))});
         #1;
         chk({n, "_rready"}, 64'(rready), 64'd1);
         check_resp($sformatf("%s_b%0d", n, i));
         step();
      end
      rvalid = 1'b0; rlast = 1'b0;
   endtask

   task automatic do_write(input vec_t v, input int idx);
      string n;
      n = $sformatf("wr%0d", idx);
      awready = 1'b1; wready = 1'b1;
      sreq_valid = 1'b1; sreq_write = 1'b1; sreq_addr = v.addr; sreq_len = v.len;
      sreq_wdata = v.data; sreq_wstrb = 4'hF;
      #1 chk({n, "_ready"}, 64'(sreq_ready), 64'd1);
      step();
      for (int i = 0; i <= int'(v.exp_len); i++) begin
         if (i < int'(v.exp_len)) begin
            sreq_valid = 1'b1; sreq_wdata = v.data + 32'(i + 1);
         end else begin
            sreq_valid = 1'b0;
         end
         #1;
         if (i == 0) begin
            chk({n, "_awvalid"}, 64'(awvalid), 64'd1);
            chk({n, "_awaddr"},  64'(awaddr),  64'(v.addr));
            chk({n, "_awlen"},   64'(awlen),   64'(v.exp_len));
            chk({n, "_awsize"},  64'(awsize),  64'd2);
         end
         if (i < int'(v.exp_len)) chk($sformatf("%s_beat_ready%0d", n, i), 64'(sreq_ready), 64'd1);
         chk($sformatf("%s_wvalid%0d", n, i), 64'(wvalid), 64'd1);
         chk($sformatf("%s_wdata%0d", n, i),  64'(wdata),  64'(v.data + 32'(i)));
         chk($sformatf("%s_wlast%0d", n, i),  64'(wlast),  64'(i == int'(v.exp_len)));
         step();
      end
      #1;
      chk({n, "_w_done"},  64'(wvalid),  64'd0);
      chk({n, "_aw_done"}, 64'(awvalid), 64'd0);
      bvalid = 1'b1; bresp = v.resp; sresp_ready = 1'b1;
      sb.push_back('{write: 1'b1, data: 32'd0, err: v.exp_err, last: 1'b1});
      #1;
      chk({n, "_bready"}, 64'(bready), 64'd1);
      check_resp({n, "_b"});
      step();
      bvalid = 1'b0;
      #1 chk({n, "_idle"}, 64'(busy), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rd_tab[0] = '{32'h100,  8'd0,  32'hDEADBEEF, 2'b00, 1'b0, 8'd0};
      rd_tab[1] = '{32'h2000, 8'd2,  32'h11110000, 2'b10, 1'b1, 8'd2};
      rd_tab[2] = '{32'h3000, 8'd40, 32'hA5A50000, 2'b11, 1'b1, 8'd15};
      rd_tab[3] = '{32'h40,   8'd15, 32'h00C0FFEE, 2'b01, 1'b0, 8'd15};
      rd_tab[4] = '{32'h44,   8'd16, 32'h12340000, 2'b00, 1'b0, 8'd15};
      wr_tab[0] = '{32'h1000, 8'd3,  32'd1,        2'b10, 1'b1, 8'd3};
      wr_tab[1] = '{32'h1100, 8'd0,  32'h55,       2'b00, 1'b0, 8'd0};
      wr_tab[2] = '{32'h1200, 8'd40, 32'h100,      2'b11, 1'b1, 8'd15};

      rst = 1'b1;
      sreq_valid = 1'b1; sreq_write = 1'b0; sreq_addr = '0; sreq_len = '0;
      sreq_wdata = '0; sreq_wstrb = '0; sresp_ready = 1'b1;
      awready = 1'b0; wready = 1'b0; arready = 1'b0;
      bid = '0; bresp = '0; bvalid = 1'b0; rid = '0; rdata = '0; rresp = '0;
      rlast = 1'b0; rvalid = 1'b0;
      #1;
      chk("rst_sreq_ready", 64'(sreq_ready), 64'd0);
      chk("rst_valids", 64'({arvalid, awvalid, wvalid, sresp_valid}), 64'd0);
      chk("rst_readies", 64'({bready, rready}), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_awburst", 64'(awburst), 64'd1);
      step(); step();
      sreq_valid = 1'b0;
      rst = 1'b0;
      step();

      for (int i = 0; i < 5; i++) do_read(rd_tab[i], i);
      for (int i = 0; i < 3; i++) do_write(wr_tab[i], i);

      // read, write, read with B arriving ahead of both R responses
      awready = 1'b1; wready = 1'b1; arready = 1'b1;
      sreq_valid = 1'b1; sreq_write = 1'b0; sreq_addr = 32'h500; sreq_len = 8'd0;
      sb.push_back('{write: 1'b0, data: 32'hAAAA0001, err: 1'b0, last: 1'b1});
      #1 chk("ord_rd1_ready", 64'(sreq_ready), 64'd1);
      step();
      sreq_write = 1'b1; sreq_addr = 32'h600; sreq_wdata = 32'h77;
      sb.push_back('{write: 1'b1, data: 32'd0, err: 1'b0, last: 1'b1});
      #1 chk("ord_wr_ready", 64'(sreq_ready), 64'd1);
      step();
      sreq_write = 1'b0; sreq_addr = 32'h700;
      sb.push_back('{write: 1'b0, data: 32'hBBBB0002, err: 1'b0, last: 1'b1});
      #1 chk("ord_rd2_ready", 64'(sreq_ready), 64'd1);
      step();
      sreq_valid = 1'b0;
      bvalid = 1'b1; bresp = 2'b00; sresp_ready = 1'b1;
      #1;
      chk("ord_bready_held", 64'(bready), 64'd0);
      chk("ord_no_resp", 64'(sresp_valid), 64'd0);
      step();
      #1 chk("ord_bready_held2", 64'(bready), 64'd0);
      rvalid = 1'b1; rdata = 32'hAAAA0001; rlast = 1'b1; rresp = 2'b00;
      #1;
      chk("ord_bready_r1", 64'(bready), 64'd0);
      check_resp("ord_r1");
      step();
      rvalid = 1'b0;
      #1;
      chk("ord_bready_b", 64'(bready), 64'd1);
      check_resp("ord_b");
      step();
      bvalid = 1'b0;
      rvalid = 1'b1; rdata = 32'hBBBB0002;
      #1 check_resp("ord_r2");
      step();
      rvalid = 1'b0; rlast = 1'b0;
      #1 chk("ord_idle", 64'(busy), 64'd0);

      // fill the order FIFO with reads and free one slot with a final R beat
      for (int k = 0; k < 4; k++) begin
         sreq_valid = 1'b1; sreq_write = 1'b0; sreq_addr = 32'h800 + 32'(4 * k);
         sb.push_back('{write: 1'b0, data: 32'hC0000000 + 32'(k), err: 1'b0, last: 1'b1});
         #1 chk($sformatf("full_fill%0d", k), 64'(sreq_ready), 64'd1);
         step();
      end
      sreq_addr = 32'h810;
      #1 chk("full_ready_low", 64'(sreq_ready), 64'd0);
      step();
      #1 chk("full_ready_low2", 64'(sreq_ready), 64'd0);
      rvalid = 1'b1; rlast = 1'b1; rdata = 32'hC0000000; sresp_ready = 1'b1;
      #1;
      chk("full_ready_on_pop", 64'(sreq_ready), 64'd1);
      check_resp("full_r0");
      sb.push_back('{write: 1'b0, data: 32'hC0000004, err: 1'b0, last: 1'b1});
      step();
      sreq_valid = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         rdata = 32'hC0000000 + 32'(k);
         #1;
         if (k == 1) chk("full_fifth_araddr", 64'(araddr), 64'h810);
         check_resp($sformatf("full_r%0d", k));
         step();
      end
      rvalid = 1'b0; rlast = 1'b0; arready = 1'b0;

      // reset in the middle of a write burst
      awready = 1'b0; wready = 1'b1;
      sreq_valid = 1'b1; sreq_write = 1'b1; sreq_addr = 32'h900; sreq_len = 8'd3;
      sreq_wdata = 32'h10;
      step();
      sreq_wdata = 32'h11;
      step();
      sreq_wdata = 32'h12;
      rst = 1'b1;
      #1 chk("mrst_sreq_ready", 64'(sreq_ready), 64'd0);
      step();
      sreq_valid = 1'b0;
      #1;
      chk("mrst_awvalid", 64'(awvalid), 64'd0);
      chk("mrst_wvalid", 64'(wvalid), 64'd0);
      chk("mrst_busy", 64'(busy), 64'd0);
      rst = 1'b0;
      step();
      rd_tab[0] = '{32'hA00, 8'd0, 32'h0BADF00D, 2'b00, 1'b0, 8'd0};
      do_read(rd_tab[0], 9);

      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/lpixm_axi_master_mo.md
# lpixm_axi_master_mo

Multi-outstanding bridge from the LPI request/response master port to a single-ID AXI4 master port. Generalises the single-transaction LPI-to-AXI master with burst writes, configurable outstanding depth, and in-order mixed read/write response return. Sits between an LPI client (accelerator or DMA front end) and the system AXI interconnect.

## Interface
- BW_ADDR, 32, address width
- BW_DATA, 32, data width (multiple of 8; AxSIZE = log2(BW_DATA/8))
- BW_AXI_ID, 1, AXI ID width
- AXI_ID, 0, constant ID driven on AWID/ARID
- MAX_OUTSTANDING, 4, order-FIFO depth (power of two, ≥2)
- MAX_BURST_LEN, 16, maximum beats per burst (≤256)
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- busy  out  1  any transaction in flight or any AXI valid asserted
- sreq_valid / sreq_ready  in / out  1  request handshake
- sreq_write  in  1  1 = write, 0 = read
- sreq_addr  in  BW_ADDR  start address (first beat only)
- sreq_len  in  8  beats−1 (first beat only)
- sreq_wdata / sreq_wstrb  in  BW_DATA / BW_DATA/8  write beat payload
- sresp_valid / sresp_ready  out / in  1  response handshake
- sresp_write  out  1  response type
- sresp_data  out  BW_DATA  read data (0 for write responses)
- sresp_err  out  1  AXI RESP[1]
- sresp_last  out  1  final beat of response
- AXI AW/W/B/AR/R: standard AXI4 master signals (awid, awaddr, awlen, awsize, awburst, awvalid, awready, wdata, wstrb, wlast, wvalid, wready, bid, bresp, bvalid, bready, arid, araddr, arlen, arsize, arburst, arvalid, arready, rid, rdata, rresp, rlast, rvalid, rready)

## Operation
- Request FSM: IDLE, WBURST.
- IDLE, read: accepted when order FIFO not full and AR register empty (or draining this cycle); loads AR register (araddr, arlen = clamped len, INCR), pushes type 0 to order FIFO. Stays IDLE.
- IDLE, write: accepted when order FIFO not full, AW register empty, W register empty; loads AW register and first W beat, pushes type 1, beat counter = 0. If len = 0 stays IDLE (wlast = 1), else → WBURST.
- WBURST: sreq_ready = !wvalid | wready; each accepted beat increments counter; wlast = (counter == clamped len); on last beat → IDLE. sreq_write/addr/len ignored in WBURST.
- len clamp: sreq_len ≥ MAX_BURST_LEN → MAX_BURST_LEN−1 for both AxLEN and counter. 4 KB boundary crossing is the requester's responsibility.
- Order FIFO head selects response source: head=read → sresp mirrors R (rready = sresp_ready), pop on rvalid&rready&rlast; head=write → sresp mirrors B (bready = sresp_ready, sresp_last = 1), pop on B handshake. Non-head channel: ready held 0. FIFO empty: sresp_valid = 0, rready = bready = 0.
- sresp_err per beat = RESP[1]; errors do not abort or reorder.
- Simultaneous push and pop: count unchanged. Outstanding count = FIFO occupancy; ≤ MAX_OUTSTANDING.
- rid/bid unchecked.

## Timing
- Reset: all AXI valids 0, bready = rready = 0, sreq_ready = 0 while rst, FIFO empty, FSM IDLE, busy 0, sresp_valid 0; AxSIZE/AxBURST constant.
- AR/AW valid one cycle after request acceptance; held until handshake.
- W beat valid one cycle after sreq accept; full throughput (one beat/cycle) with wready high.
- Response path combinational: sresp_valid same cycle as rvalid/bvalid when at head; zero added latency.
- Read throughput: one AR per cycle if arready high and FIFO space.
- Reset mid-burst: all state cleared immediately; no partial recovery.

## Test plan
- Single read addr 0x100 len 0, rdata 0xDEADBEEF OKAY → arvalid cycle after accept, arlen 0, arsize 2; sresp data 0xDEADBEEF, last 1, err 0, write 0.
- Write len 3, data 1..4, wready high → awlen 3, four W beats back-to-back, wlast only on beat 4; bresp SLVERR → sresp write 1, err 1, last 1.
- Issue read, write, read; AXI returns B before either R → bready stays 0 until first read's rlast; responses delivered R, B, R order.
- Five reads with MAX_OUTSTANDING 4, no R returned → fifth sreq_ready low; single R handshake with rlast frees it the same cycle as pop.
- sreq_len 40 with MAX_BURST_LEN 16 → arlen/awlen 15, write counter ends after 16 beats.
- Assert rst during WBURST beat 2 → next cycle awvalid/wvalid 0, busy 0, FSM IDLE, new read accepted normally after release.
